// File: rtl/seg_label_pkg.sv
// Shared definitions for the segmentation labeller: frame FSM states,
// segment-pipeline constants and the ceil-log2 helper used to size ports.
package seg_label_pkg;

  localparam int SEG_UNITS     = 4;
  localparam int SEG_INT_BITW  = 5;
  localparam int SEG_FRAC_BITW = 8;
  localparam int LABEL_W       = 2;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACCUM    = 1'b1
  } frame_state_t;

  // ceil(log2(x)), never below 1 so that derived widths stay legal
  // for degenerate or unset window sizes.
  function automatic int log2c(input int x);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < x) r = i + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/seg_label_argmax2.sv
// Registered pairwise signed compare. The winner's score and index are
// captured on each rising edge; equal scores resolve to side a, which the
// caller always wires to the lower channel index.
// Ports: clock, rst (sync, active-high); a_score/a_idx, b_score/b_idx
// candidates; win_score/win_idx registered winner.
module argmax2
  import seg_label_pkg::*;
#(
  parameter int DATA_W = SEG_INT_BITW + SEG_FRAC_BITW
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] a_score,
  input  logic [LABEL_W-1:0]       a_idx,
  input  logic signed [DATA_W-1:0] b_score,
  input  logic [LABEL_W-1:0]       b_idx,
  output logic signed [DATA_W-1:0] win_score,
  output logic [LABEL_W-1:0]       win_idx
);

  always_ff @(posedge clock) begin
    if (rst) begin
      win_score <= '0;
      win_idx   <= '0;
    end else if (a_score >= b_score) begin
      win_score <= a_score;
      win_idx   <= a_idx;
    end else begin
      win_score <= b_score;
      win_idx   <= b_idx;
    end
  end

endmodule

// File: rtl/seg_label.sv
// Per-pixel segmentation labeller: picks the highest of four signed channel
// scores through a two-stage registered argmax tree, and accumulates a
// per-class histogram over each complete W_HEIGHT x W_WIDTH frame.
// Ports:
//   clock, rst          single clock, synchronous active-high reset
//   in_enable, in_y     pixel valid and four packed scores (channel 0 first)
//   in_vcnt, in_hcnt    pixel coordinates
//   out_enable, out_label, out_score, out_vcnt, out_hcnt
//                       winning label/score, 2 cycles after the input
//   out_hist            class counts of the last complete frame (class 0 first)
//   out_hist_valid      one-cycle pulse when out_hist is loaded
module seg_label
  import seg_label_pkg::*;
#(
  parameter  int W_HEIGHT   = -1,
  parameter  int W_WIDTH    = -1,
  parameter  int INT_BITW   = SEG_INT_BITW,
  parameter  int FRAC_BITW  = SEG_FRAC_BITW,
  localparam int V_BITW     = log2c(W_HEIGHT),
  localparam int H_BITW     = log2c(W_WIDTH),
  localparam int CNT_BITW   = log2c(W_HEIGHT * W_WIDTH + 1),
  localparam int FIXED_BITW = INT_BITW + FRAC_BITW
) (
  input  logic                             clock,
  input  logic                             rst,
  input  logic                             in_enable,
  input  logic [0:FIXED_BITW*SEG_UNITS-1]  in_y,
  input  logic [V_BITW-1:0]                in_vcnt,
  input  logic [H_BITW-1:0]                in_hcnt,
  output logic                             out_enable,
  output logic [LABEL_W-1:0]               out_label,
  output logic [FIXED_BITW-1:0]            out_score,
  output logic [V_BITW-1:0]                out_vcnt,
  output logic [H_BITW-1:0]                out_hcnt,
  output logic [0:CNT_BITW*SEG_UNITS-1]    out_hist,
  output logic                             out_hist_valid
);

  function automatic logic [CNT_BITW-1:0] sat_inc(input logic [CNT_BITW-1:0] v);
    return (&v) ? v : v + CNT_BITW'(1);
  endfunction

  // ---- stage 0: unpack channel scores ----
  logic signed [FIXED_BITW-1:0] ch_p0 [SEG_UNITS];

  for (genvar k = 0; k < SEG_UNITS; k++) begin : g_ch
    assign ch_p0[k] = in_y[k*FIXED_BITW +: FIXED_BITW];
  end

  // ---- stage 1: ch0 vs ch1, ch2 vs ch3 ----
  logic signed [FIXED_BITW-1:0] score01_p1, score23_p1;
  logic [LABEL_W-1:0]           idx01_p1, idx23_p1;
  logic                         vld_p1;
  logic [V_BITW-1:0]            vcnt_p1;
  logic [H_BITW-1:0]            hcnt_p1;

  argmax2 #(.DATA_W(FIXED_BITW)) u_am01 (
    .clock(clock), .rst(rst),
    .a_score(ch_p0[0]), .a_idx(2'd0),
    .b_score(ch_p0[1]), .b_idx(2'd1),
    .win_score(score01_p1), .win_idx(idx01_p1)
  );

  argmax2 #(.DATA_W(FIXED_BITW)) u_am23 (
    .clock(clock), .rst(rst),
    .a_score(ch_p0[2]), .a_idx(2'd2),
    .b_score(ch_p0[3]), .b_idx(2'd3),
    .win_score(score23_p1), .win_idx(idx23_p1)
  );

  always_ff @(posedge clock) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      vcnt_p1 <= '0;
      hcnt_p1 <= '0;
    end else begin
      vld_p1  <= in_enable;
      vcnt_p1 <= in_vcnt;
      hcnt_p1 <= in_hcnt;
    end
  end

  // ---- stage 2: final compare, drives the pixel outputs ----
  logic signed [FIXED_BITW-1:0] score_p2;

  argmax2 #(.DATA_W(FIXED_BITW)) u_am_fin (
    .clock(clock), .rst(rst),
    .a_score(score01_p1), .a_idx(idx01_p1),
    .b_score(score23_p1), .b_idx(idx23_p1),
    .win_score(score_p2), .win_idx(out_label)
  );

  assign out_score = score_p2;

  always_ff @(posedge clock) begin
    if (rst) begin
      out_enable <= 1'b0;
      out_vcnt   <= '0;
      out_hcnt   <= '0;
    end else begin
      out_enable <= vld_p1;
      out_vcnt   <= vcnt_p1;
      out_hcnt   <= hcnt_p1;
    end
  end

  // ---- stage 3: frame histogram on the stage-2 pixel stream ----
  frame_state_t          state, state_next;
  logic [CNT_BITW-1:0]   acc      [SEG_UNITS];
  logic [CNT_BITW-1:0]   cnt_upd  [SEG_UNITS];
  logic [CNT_BITW-1:0]   acc_next [SEG_UNITS];
  logic                  hist_load;
  logic                  sof, eof;

  assign sof = out_enable && (out_vcnt == '0) && (out_hcnt == '0);
  assign eof = out_enable && (out_vcnt == V_BITW'(W_HEIGHT - 1))
                          && (out_hcnt == H_BITW'(W_WIDTH - 1));

  always_ff @(posedge clock) begin
    if (rst) state <= WAIT_SOF;
    else     state <= state_next;
  end

  // cnt_upd holds the counts including the current pixel; on the last pixel
  // of a frame it is what gets published, while the accumulators restart.
  always_comb begin
    state_next = state;
    hist_load  = 1'b0;
    for (int k = 0; k < SEG_UNITS; k++) cnt_upd[k] = acc[k];
    case (state)
      WAIT_SOF: begin
        if (sof) begin
          for (int k = 0; k < SEG_UNITS; k++) cnt_upd[k] = '0;
          cnt_upd[out_label] = CNT_BITW'(1);
          state_next         = ACCUM;
        end
      end
      ACCUM: begin
        if (sof) begin
          // A fresh (0,0) mid-frame means the source restarted the frame.
          for (int k = 0; k < SEG_UNITS; k++) cnt_upd[k] = '0;
          cnt_upd[out_label] = CNT_BITW'(1);
        end else if (out_enable) begin
          cnt_upd[out_label] = sat_inc(acc[out_label]);
          if (eof) begin
            hist_load  = 1'b1;
            state_next = WAIT_SOF;
          end
        end
      end
      default: state_next = WAIT_SOF;
    endcase
    for (int k = 0; k < SEG_UNITS; k++) acc_next[k] = hist_load ? '0 : cnt_upd[k];
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      for (int k = 0; k < SEG_UNITS; k++) acc[k] <= '0;
      out_hist       <= '0;
      out_hist_valid <= 1'b0;
    end else begin
      for (int k = 0; k < SEG_UNITS; k++) acc[k] <= acc_next[k];
      if (hist_load) begin
        for (int k = 0; k < SEG_UNITS; k++) out_hist[k*CNT_BITW +: CNT_BITW] <= cnt_upd[k];
      end
      out_hist_valid <= hist_load;
    end
  end

endmodule
